aud_adc_rx: RTL and testbench
=============================

# aud_adc_rx

Audio ADC serial receiver for the board's audio codec capture path, the counterpart of the DAC-side transmitter that drives `AUD_DACDAT`. The codec is bus master: it drives `AUD_BCLK` and `AUD_ADCLRCK`, and the block samples `AUD_ADCDAT`. Each left/right word pair is deserialized in the `clk` domain and buffered in a small FIFO. Pairs leave the block on a valid/ready stream that an Avalon-MM or DMA wrapper drains for the HPS.

## Interface
- `DATA_W`, default 16: captured bits per channel, MSB first.
- `FIFO_DEPTH`, default 4: number of buffered `{left,right}` pairs; must be a power of two, 2 or more.
- `clk` input 1: system clock (50 MHz `CLOCK_50` domain); must be at least 6× the BCLK frequency.
- `reset_n` input 1: reset, asynchronous and active-low.
- `aud_bclk` input 1: codec bit clock; asynchronous to `clk`.
- `aud_adclrck` input 1: codec ADC frame clock; low = left, high = right; asynchronous.
- `aud_adcdat` input 1: codec serial data; changes on falling BCLK; asynchronous.
- `sample_ready` input 1: consumer accepts the head pair.
- `ovf_clr` input 1: one-cycle pulse that clears `ovf`.
- `sample_valid` output 1: FIFO not empty.
- `sample_left` output DATA_W: head pair, left word.
- `sample_right` output DATA_W: head pair, right word.
- `ovf` output 1: sticky flag; a pair was dropped because the FIFO was full.

## Operation
- **Input synchronization:** each of the three codec inputs passes through a 2-FF synchronizer. A further flop holds the previous BCLK value. `bclk_rise` = synced BCLK high and previous BCLK low. All capture logic acts only on `bclk_rise` cycles.
- **Frame edge detection:** `lr_prev` holds the LRCK value sampled at the last `bclk_rise`. A frame edge is a `bclk_rise` on which synced LRCK differs from `lr_prev`.
- **State machine** (`HUNT`, `SHIFT`, `PAD`):
  - `HUNT`: the reset state. Waits for an LRCK falling frame edge (start of a left word), then goes to `SHIFT` with the channel set to left. Rising frame edges are ignored in `HUNT`.
  - `SHIFT`: on each `bclk_rise` with no frame edge, shifts `aud_adcdat` into the word register and increments `bit_cnt`. When `bit_cnt` reaches DATA_W:
    - if the channel is left, latches `left_word`;
    - if the channel is right, issues a one-cycle push of `{left_word, right_word}`;
    - then goes to `PAD`.
  - `PAD`: ignores slot padding bits until the next frame edge.
  - Any frame edge in `SHIFT` or `PAD` restarts capture: the channel is set to the new LRCK value and `bit_cnt` is cleared.
- **I2S one-bit delay:** the bit sampled on a frame-edge `bclk_rise` is discarded, so the MSB is the following bit.
- **Short word:** a frame edge in `SHIFT` before `bit_cnt` reaches DATA_W discards the partial word, with no push. A short left word also invalidates the pair: the following right word does not push.
- **FIFO:** circular buffer of FIFO_DEPTH entries, 2·DATA_W bits wide, with a count of width log2(FIFO_DEPTH)+1.
  - A pop occurs when `sample_valid` and `sample_ready` are both high.
  - A push when count < FIFO_DEPTH is accepted.
  - A push when count = FIFO_DEPTH is accepted only if a pop occurs in the same cycle (count unchanged). Otherwise the pair is dropped and `ovf` is set.
  - A pop when empty is a no-op. Pointers wrap modulo FIFO_DEPTH.
- **Overflow flag:** `ovf_clr` clears `ovf`. If a set and `ovf_clr` occur in the same cycle, the set wins.

## Timing
- **Reset values:** `sample_valid`, `sample_left`, `sample_right` and `ovf` are all 0; state `HUNT`; FIFO empty; synchronizers 0.
- **Reset mid-operation:** asserting `reset_n` at any time aborts capture immediately. After release, capture restarts in `HUNT`.
- **Capture-to-valid latency:** the pin-level BCLK rising edge carrying right bit 0 (LSB) is followed by `sample_valid` high 4 `clk` cycles later, when the FIFO was empty (+1 cycle for synchronizer sampling phase).
- **Output behaviour:**
  - `sample_left` and `sample_right` show the FIFO head.
  - While `sample_valid` is high and `sample_ready` is low, the head pair is held stable.
  - After a pop, the next head appears on the following cycle.
- **Throughput:** a pop on every cycle is supported; `sample_ready` may be held high permanently.

## Configuration
- `AUD_RX_LJ_EN` defined: left-justified format. The bit sampled on the frame-edge `bclk_rise` is the MSB: it is captured and `bit_cnt` becomes 1.
- `AUD_RX_LJ_EN` undefined (default): I2S format with the one-bit delay described above.
- No other behaviour differs between the two builds.

## Test plan
- **Basic I2S pair:** I2S, BCLK = clk/16, 32-bit slots, left = 0x8001, right = 0x7FFE, `sample_ready` = 1 → exactly one pair 0x8001/0x7FFE; `sample_valid` high 4–5 cycles after right LSB; `ovf` = 0.
- **Backpressure and overflow:** `sample_ready` = 0, six frames with left = n, right = ~n → `ovf` = 1 after the 5th frame. Then raise `sample_ready` → pairs 1–4 drain in order, then `sample_valid` = 0.
- **Overflow clear:** `ovf_clr` pulsed in the same cycle as a dropped push → `ovf` stays 1. `ovf_clr` alone → `ovf` = 0 next cycle.
- **Short word:** LRCK toggles after 10 right bits → no push. Next full frame 0x1234/0xABCD → received correctly.
- **Reset mid-word:** `reset_n` low during left bit 7 → all outputs 0. After release, the first pair is from the first complete frame after the next LRCK falling edge.
- **Left-justified build:** with `AUD_RX_LJ_EN`, an LJ frame 0x00FF/0xFF00 → received exactly. The same stimulus on a default build → 0x01FE/0xFE00.

Source files
------------

// File: rtl/aud_adc_rx.sv
// Audio codec ADC serial receiver: deserializes I2S (or, with AUD_RX_LJ_EN defined,
// left-justified) left/right pairs from codec-mastered BCLK/LRCK and buffers them in a FIFO.
module aud_adc_rx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  input  logic              sample_ready,
  input  logic              ovf_clr,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {HUNT, SHIFT, PAD} state_t;

  state_t state, state_d;

  logic bclk_s1, bclk_s2, bclk_prev;
  logic lr_s1, lr_s2, lr_prev;
  logic dat_s1, dat_s2;
  logic bclk_rise, frame_edge;

  logic start_word, shift_bit, word_done;
  logic chan, pair_ok;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   word, word_next, left_word;
  logic                push;
  logic [2*DATA_W-1:0] push_data;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                pop, full, wr_en, drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_prev <= 1'b0;
      lr_s1     <= 1'b0;
      lr_s2     <= 1'b0;
      dat_s1    <= 1'b0;
      dat_s2    <= 1'b0;
    end else begin
      bclk_s1   <= aud_bclk;
      bclk_s2   <= bclk_s1;
      bclk_prev <= bclk_s2;
      lr_s1     <= aud_adclrck;
      lr_s2     <= lr_s1;
      dat_s1    <= aud_adcdat;
      dat_s2    <= dat_s1;
    end
  end

  assign bclk_rise  = bclk_s2 & ~bclk_prev;
  assign frame_edge = bclk_rise & (lr_s2 ^ lr_prev);
  assign word_next  = {word[DATA_W-2:0], dat_s2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= HUNT;
    else          state <= state_d;
  end

  // Only a falling LRCK edge (start of a left word) can leave HUNT, so pairs stay aligned.
  always_comb begin
    state_d    = state;
    start_word = 1'b0;
    shift_bit  = 1'b0;
    word_done  = 1'b0;
    if (bclk_rise) begin
      case (state)
        HUNT: begin
          if (frame_edge && !lr_s2) begin
            start_word = 1'b1;
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_edge) begin
            start_word = 1'b1;
          end else begin
            shift_bit = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              word_done = 1'b1;
              state_d   = PAD;
            end
          end
        end
        PAD: begin
          if (frame_edge) begin
            start_word = 1'b1;
            state_d    = SHIFT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // pair_ok is cleared at every left start, so a short left word blocks the following right push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev   <= 1'b0;
      chan      <= 1'b0;
      pair_ok   <= 1'b0;
      bit_cnt   <= '0;
      word      <= '0;
      left_word <= '0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= 1'b0;
      if (bclk_rise) lr_prev <= lr_s2;
      if (start_word) begin
        chan <= lr_s2;
        if (!lr_s2) pair_ok <= 1'b0;
`ifdef AUD_RX_LJ_EN
        word    <= {{(DATA_W-1){1'b0}}, dat_s2};
        bit_cnt <= BIT_ONE;
`else
        bit_cnt <= '0;
`endif
      end else if (shift_bit) begin
        word    <= word_next;
        bit_cnt <= bit_cnt + BIT_ONE;
      end
      if (word_done) begin
        if (!chan) begin
          left_word <= word_next;
          pair_ok   <= 1'b1;
        end else if (pair_ok) begin
          push      <= 1'b1;
          push_data <= {left_word, word_next};
        end
      end
    end
  end

  assign pop   = sample_valid & sample_ready;
  assign full  = (count == CNT_FULL);
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Outputs read zero while empty so stale entries never leak out.
  assign sample_valid = (count != '0);
  assign {sample_left, sample_right} = sample_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_aud_adc_rx.sv
// Self-checking bench for aud_adc_rx: directed frames plus randomized slots, checked
// against a slot-level model of the serial format and a queue model of the FIFO.
module tb_aud_adc_rx;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef AUD_RX_LJ_EN
  localparam int OFF_RX = 0;
  localparam logic [31:0] LJ_EXPECT = 32'h00FF_FF00;
`else
  localparam int OFF_RX = 1;
  localparam logic [31:0] LJ_EXPECT = 32'h01FE_FE00;
`endif
  localparam logic NATIVE_LJ = (OFF_RX == 0);

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic aud_bclk = 1'b1, aud_adclrck = 1'b1, aud_adcdat = 1'b0;
  logic sample_ready = 1'b0, ovf_clr = 1'b0;
  logic sample_valid, ovf;
  logic [DW-1:0] sample_left, sample_right;

  int n_cmp = 0;
  int n_fail = 0;
  int cycle = 0;
  logic [2*DW-1:0] exp_q[$];
  logic exp_ovf = 1'b0, synced = 1'b0, seen_high = 1'b0;
  logic ready_cmd = 1'b0, rand_ready = 1'b0;
  int pop_cnt = 0;
  logic [2*DW-1:0] last_pop = '0;
  logic lat_arm = 1'b0;
  int lat_cycle = 0, lat_meas = -1;
  logic valid_prev = 1'b0;

  aud_adc_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
    .sample_ready(sample_ready), .ovf_clr(ovf_clr),
    .sample_valid(sample_valid), .sample_left(sample_left), .sample_right(sample_right),
    .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    sample_ready = rand_ready ? ($urandom_range(3) != 0) : ready_cmd;
  end

  // Pop monitor: every accepted pair must match the head of the model queue.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (lat_arm && lat_meas < 0 && sample_valid && !valid_prev) lat_meas = cycle - lat_cycle;
      if (sample_valid && sample_ready) begin
        checkOutput("pop_avail", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          checkOutput("pop_pair", {sample_left, sample_right}, exp_q[0]);
          void'(exp_q.pop_front());
        end
        pop_cnt++;
        last_pop = {sample_left, sample_right};
      end
    end
    valid_prev = sample_valid;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] make_slot(input logic [DW-1:0] w, input logic lj_tx, input logic rand_pad);
    logic [31:0] b;
    int off;
    b   = rand_pad ? 32'($urandom) : 32'h0;
    off = lj_tx ? 0 : 1;
    for (int i = 0; i < DW; i++) b[31-(off+i)] = w[DW-1-i];
    return b;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [31:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[DW-1-i] = b[31-(OFF_RX+i)];
    return r;
  endfunction

  task automatic model_push(input logic [2*DW-1:0] pair);
    if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(pair);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", 64'(sample_valid), 64'd0);
    checkOutput("rst_left", 64'(sample_left), 64'd0);
    checkOutput("rst_right", 64'(sample_right), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    synced = 1'b0;
    seen_high = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One slot: data and LRCK change on falling BCLK, BCLK = clk/16.
  task automatic send_slot(input logic lr, input logic [31:0] bits, input int len, input int rst_k,
                           input int push_k, input logic [2*DW-1:0] pair, input logic push_en,
                           input logic clr_at_push);
    for (int k = 0; k < len; k++) begin
      aud_bclk = 1'b0;
      if (k == 0) aud_adclrck = lr;
      aud_adcdat = bits[31-k];
      repeat (8) @(posedge clk);
      #1;
      aud_bclk = 1'b1;
      if (k == push_k) begin
        lat_cycle = cycle;
        if (push_en) model_push(pair);
      end
      if (k == rst_k) pulse_reset();
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (clr_at_push && k == push_k) ovf_clr = (c == 2);
      end
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] lw, input logic [DW-1:0] rw, input int llen,
                               input int rlen, input logic lj_tx, input logic rand_pad,
                               input int rst_k, input logic clr_at_push);
    logic [31:0] lb, rb;
    logic left_ok, push_en;
    lb = make_slot(lw, lj_tx, rand_pad);
    rb = make_slot(rw, lj_tx, rand_pad);
    if (seen_high) synced = 1'b1;
    left_ok = synced && (llen >= OFF_RX + DW);
    send_slot(1'b0, lb, llen, rst_k, -1, '0, 1'b0, 1'b0);
    if (rst_k >= 0 && rst_k < llen) left_ok = 1'b0;
    seen_high = 1'b1;
    push_en = left_ok && (rlen >= OFF_RX + DW);
    send_slot(1'b1, rb, rlen, -1, OFF_RX + DW - 1, {extract(lb), extract(rb)}, push_en, clr_at_push);
  endtask

  task automatic send_preamble();
    send_slot(1'b1, 32'($urandom), 32, -1, -1, '0, 1'b0, 1'b0);
    seen_high = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sample_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_empty"}, 64'(exp_q.size()), 64'd0);
    checkOutput({tag, "_valid"}, 64'(sample_valid), 64'd0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 64'(sample_valid), 64'd0);
    checkOutput("reset_left", 64'(sample_left), 64'd0);
    checkOutput("reset_right", 64'(sample_right), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    ready_cmd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_preamble();
    pop_cnt = 0;
    lat_meas = -1;
    lat_arm = 1'b1;
    applyStimulus(16'h8001, 16'h7FFE, 32, 32, NATIVE_LJ, 1'b1, -1, 1'b0);
    lat_arm = 1'b0;
    checkOutput("basic_pops", 64'(pop_cnt), 64'd1);
    checkOutput("basic_pair", 64'(last_pop), 64'h8001_7FFE);
    checkOutput("basic_latency_ok", 64'(lat_meas >= 4 && lat_meas <= 5), 64'd1);
    checkOutput("basic_ovf", 64'(ovf), 64'd0);

    ready_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 1; n <= 6; n++) begin
      applyStimulus(16'(n), ~16'(n), 32, 32, NATIVE_LJ, 1'b1, -1, 1'b0);
      @(negedge clk);
      if (n == 4) checkOutput("bp_ovf_after4", 64'(ovf), 64'd0);
      if (n == 5) checkOutput("bp_ovf_after5", 64'(ovf), 64'd1);
    end
    checkOutput("bp_ovf_model", 64'(ovf), 64'(exp_ovf));
    checkOutput("bp_hold_valid", 64'(sample_valid), 64'd1);
    checkOutput("bp_hold_head", {sample_left, sample_right}, 64'h0001_FFFE);

    pulse_clr();
    checkOutput("clr_alone", 64'(ovf), 64'd0);
    applyStimulus(16'd7, ~16'd7, 32, 32, NATIVE_LJ, 1'b1, -1, 1'b1);
    @(negedge clk);
    checkOutput("clr_set_wins", 64'(ovf), 64'd1);
    checkOutput("clr_set_model", 64'(exp_ovf), 64'd1);
    pulse_clr();
    checkOutput("clr_again", 64'(ovf), 64'd0);

    pop_cnt = 0;
    ready_cmd = 1'b1;
    wait_drain("bp_drain");
    checkOutput("bp_drain_pops", 64'(pop_cnt), 64'd4);
    checkOutput("bp_drain_last", 64'(last_pop), 64'h0004_FFFB);

    pop_cnt = 0;
    applyStimulus(16'h1111, 16'h2222, 32, OFF_RX + 10, NATIVE_LJ, 1'b1, -1, 1'b0);
    applyStimulus(16'h5555, 16'h6666, OFF_RX + 5, 32, NATIVE_LJ, 1'b1, -1, 1'b0);
    applyStimulus(16'h1234, 16'hABCD, 32, 32, NATIVE_LJ, 1'b1, -1, 1'b0);
    wait_drain("short");
    checkOutput("short_pops", 64'(pop_cnt), 64'd1);
    checkOutput("short_pair", 64'(last_pop), 64'h1234_ABCD);

    ready_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(16'hA5A5, 16'h5A5A, 32, 32, NATIVE_LJ, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("prerst_valid", 64'(sample_valid), 64'd1);
    applyStimulus(16'hDEAD, 16'hBEEF, 32, 32, NATIVE_LJ, 1'b1, OFF_RX + 8, 1'b0);
    applyStimulus(16'h0C0C, 16'hC0C0, 32, 32, NATIVE_LJ, 1'b1, -1, 1'b0);
    pop_cnt = 0;
    ready_cmd = 1'b1;
    wait_drain("rst");
    checkOutput("rst_pops", 64'(pop_cnt), 64'd1);
    checkOutput("rst_first_pair", 64'(last_pop), 64'h0C0C_C0C0);

    pop_cnt = 0;
    applyStimulus(16'h00FF, 16'hFF00, 32, 32, 1'b1, 1'b0, -1, 1'b0);
    wait_drain("lj");
    checkOutput("lj_pops", 64'(pop_cnt), 64'd1);
    checkOutput("lj_pair", 64'(last_pop), 64'(LJ_EXPECT));

    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      int llen, rlen;
      llen = ($urandom_range(3) == 0) ? int'($urandom_range(2, 31)) : 32;
      rlen = ($urandom_range(3) == 0) ? int'($urandom_range(2, 31)) : 32;
      applyStimulus(16'($urandom), 16'($urandom), llen, rlen, NATIVE_LJ, 1'b1, -1, 1'b0);
    end
    rand_ready = 1'b0;
    ready_cmd = 1'b1;
    wait_drain("rand");
    checkOutput("rand_ovf", 64'(ovf), 64'(exp_ovf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
